// File: rtl/branch_verify_if.sv
// Shared branch-verify types and the EX-to-verify handshake bundle.
// The package lives here so it compiles ahead of both the interface and the design.
package bv_pkg;
   typedef logic [31:0] virt_t;

   typedef struct packed {
      logic ex;
      logic eret;
      logic tlb_op;
   } pipeline_flush_t;

   typedef struct packed {
      logic  valid;
      logic  br_op;
      logic  br_taken;
      virt_t target;
   } predict_result_t;

   typedef struct packed {
      logic [1:0] cnt;
      logic [9:0] hist;
   } BHT_entry_t;

   typedef struct packed {
      virt_t      pc;
      logic [2:0] br_type;
      logic       ready;
      logic       predict_sucess;
      logic       is_taken;
      virt_t      correct_target;
      BHT_entry_t predict_entry;
   } verify_result_t;
endpackage

interface branch_verify_if #(parameter int CNT_W = 32);
   import bv_pkg::*;

   pipeline_flush_t  pipeline_flush;
   logic             es_fire;
   virt_t            es_pc;
   logic [2:0]       es_br_type;
   logic             es_br_taken;
   virt_t            es_br_target;
   predict_result_t  es_pred;
   BHT_entry_t       es_pred_entry;
   logic             ds_fire;
   logic             fs_redirect_ack;
   verify_result_t   es_to_bpu_bus;
   logic             correct_finish;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] miss_cnt;

   modport master (
      output pipeline_flush, es_fire, es_pc, es_br_type, es_br_taken,
      output es_br_target, es_pred, es_pred_entry, ds_fire, fs_redirect_ack,
      input  es_to_bpu_bus, correct_finish, br_cnt, miss_cnt
   );

   modport slave (
      input  pipeline_flush, es_fire, es_pc, es_br_type, es_br_taken,
      input  es_br_target, es_pred, es_pred_entry, ds_fire, fs_redirect_ack,
      output es_to_bpu_bus, correct_finish, br_cnt, miss_cnt
   );
endinterface

// File: rtl/branch_verify.sv
// Resolves branches in EX against their fetch-time prediction, reports to the
// BPU one cycle later and tracks the misprediction correction sequence.
module branch_verify
   import bv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic             clk,
   input logic             resetn,
   branch_verify_if.slave  bv
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_DS  = 2'd1,
      REDIRECT = 2'd2
   } state_e;

   state_e           state_q, state_d;
   verify_result_t   bus_q, bus_d;
   logic             cf_q, cf_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic  flush, br_fire, pred_taken, pred_ok;
   virt_t seq_pc, act_tgt, pred_tgt;

   assign flush = bv.pipeline_flush.ex | bv.pipeline_flush.eret
                | bv.pipeline_flush.tlb_op;

   // Only branches on the correct path (IDLE) are verified.
   assign br_fire = bv.es_fire && (bv.es_br_type != 3'd0)
                 && (state_q == IDLE) && !flush;

   assign seq_pc     = bv.es_pc + 32'd8;
   assign act_tgt    = bv.es_br_taken ? bv.es_br_target : seq_pc;
   assign pred_taken = bv.es_pred.valid && bv.es_pred.br_op
                    && bv.es_pred.br_taken;
   assign pred_tgt   = pred_taken ? bv.es_pred.target : seq_pc;
   assign pred_ok    = (pred_taken == bv.es_br_taken)
                    && (!bv.es_br_taken || pred_tgt == bv.es_br_target);

   always_comb begin
      state_d    = state_q;
      cf_d       = 1'b0;
      bus_d      = bus_q;
      bus_d.ready = 1'b0;
      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;

      if (br_fire) begin
         bus_d.pc             = bv.es_pc;
         bus_d.br_type        = bv.es_br_type;
         bus_d.ready          = 1'b1;
         bus_d.predict_sucess = pred_ok;
         bus_d.is_taken       = bv.es_br_taken;
         bus_d.correct_target = act_tgt;
         bus_d.predict_entry  = bv.es_pred_entry;
         if (!(&br_cnt_q))
            br_cnt_d = br_cnt_q + CNT_W'(1);
         if (!pred_ok && !(&miss_cnt_q))
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         IDLE:     if (br_fire && !pred_ok) state_d = WAIT_DS;
         WAIT_DS:  if (bv.ds_fire) state_d = REDIRECT;
         REDIRECT: if (bv.fs_redirect_ack) begin
            state_d = IDLE;
            cf_d    = 1'b1;
         end
         default:  state_d = IDLE;
      endcase

      if (flush) begin
         state_d = IDLE;
         cf_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         bus_q      <= '0;
         cf_q       <= 1'b0;
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         bus_q      <= bus_d;
         cf_q       <= cf_d;
         br_cnt_q   <= br_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign bv.es_to_bpu_bus  = bus_q;
   assign bv.correct_finish = cf_q;
   assign bv.br_cnt         = br_cnt_q;
   assign bv.miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_branch_verify.sv
// Directed bench for branch_verify with 4-bit counters so saturation is
// reachable in a short run.
module tb_branch_verify;
   import bv_pkg::*;

   localparam int CW = 4;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;

   branch_verify_if #(.CNT_W(CW)) bvi ();

   branch_verify #(.CNT_W(CW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bv     (bvi.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in;
      bvi.pipeline_flush  = '0;
      bvi.es_fire         = 1'b0;
      bvi.es_pc           = '0;
      bvi.es_br_type      = '0;
      bvi.es_br_taken     = 1'b0;
      bvi.es_br_target    = '0;
      bvi.es_pred         = '0;
      bvi.es_pred_entry   = '0;
      bvi.ds_fire         = 1'b0;
      bvi.fs_redirect_ack = 1'b0;
   endtask

   task automatic drive_br(input logic [31:0] pc, input logic [2:0] ty,
                           input logic tk, input logic [31:0] tgt,
                           input logic pv, input logic ptk,
                           input logic [31:0] ptgt);
      bvi.es_fire          = 1'b1;
      bvi.es_pc            = pc;
      bvi.es_br_type       = ty;
      bvi.es_br_taken      = tk;
      bvi.es_br_target     = tgt;
      bvi.es_pred.valid    = pv;
      bvi.es_pred.br_op    = pv;
      bvi.es_pred.br_taken = ptk;
      bvi.es_pred.target   = ptgt;
      bvi.es_pred_entry    = 12'hA5C;
   endtask

   task automatic do_mispredict;
      drive_br(32'h80000100, 3'd1, 1'b0, 32'h80000200,
               1'b1, 1'b1, 32'h80000200);
      tick;
      clear_in;
      bvi.ds_fire = 1'b1;
      tick;
      clear_in;
      bvi.fs_redirect_ack = 1'b1;
      tick;
      clear_in;
      tick;
   endtask

   task automatic test_reset;
      clear_in;
      resetn = 1'b1;
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (bvi.es_to_bpu_bus !== '0) begin
         errors++;
         $display("FAIL reset_bus: got %h expected 0", bvi.es_to_bpu_bus);
      end
      checks++;
      if (bvi.correct_finish !== 1'b0 || bvi.br_cnt !== 4'd0
          || bvi.miss_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_regs: got cf=%b br=%h miss=%h expected 0 0 0",
                  bvi.correct_finish, bvi.br_cnt, bvi.miss_cnt);
      end
      checks++;
      if (dut.state_q !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d expected 0", dut.state_q);
      end
      @(negedge clk);
      resetn = 1'b1;
      tick;
   endtask

   task automatic test_correct_taken;
      drive_br(32'h80000100, 3'd1, 1'b1, 32'h80000200,
               1'b1, 1'b1, 32'h80000200);
      tick;
      clear_in;
      checks++;
      if (bvi.es_to_bpu_bus.ready !== 1'b1
          || bvi.es_to_bpu_bus.predict_sucess !== 1'b1
          || bvi.es_to_bpu_bus.is_taken !== 1'b1) begin
         errors++;
         $display("FAIL ct_flags: got rdy=%b ok=%b tk=%b expected 1 1 1",
                  bvi.es_to_bpu_bus.ready, bvi.es_to_bpu_bus.predict_sucess,
                  bvi.es_to_bpu_bus.is_taken);
      end
      checks++;
      if (bvi.es_to_bpu_bus.correct_target !== 32'h80000200
          || bvi.es_to_bpu_bus.pc !== 32'h80000100
          || bvi.es_to_bpu_bus.br_type !== 3'd1
          || bvi.es_to_bpu_bus.predict_entry !== 12'hA5C) begin
         errors++;
         $display("FAIL ct_fields: got tgt=%h pc=%h ty=%0d ent=%h",
                  bvi.es_to_bpu_bus.correct_target, bvi.es_to_bpu_bus.pc,
                  bvi.es_to_bpu_bus.br_type, bvi.es_to_bpu_bus.predict_entry);
      end
      checks++;
      if (dut.state_q !== 2'd0 || bvi.br_cnt !== 4'd1
          || bvi.miss_cnt !== 4'd0) begin
         errors++;
         $display("FAIL ct_cnt: got st=%0d br=%0d miss=%0d expected 0 1 0",
                  dut.state_q, bvi.br_cnt, bvi.miss_cnt);
      end
      tick;
      checks++;
      if (bvi.es_to_bpu_bus.ready !== 1'b0
          || bvi.es_to_bpu_bus.correct_target !== 32'h80000200) begin
         errors++;
         $display("FAIL ct_hold: got rdy=%b tgt=%h expected 0 80000200",
                  bvi.es_to_bpu_bus.ready, bvi.es_to_bpu_bus.correct_target);
      end
   endtask

   task automatic test_mispredict_nt;
      drive_br(32'h80000100, 3'd1, 1'b0, 32'h80000200,
               1'b1, 1'b1, 32'h80000200);
      tick;
      clear_in;
      checks++;
      if (bvi.es_to_bpu_bus.ready !== 1'b1
          || bvi.es_to_bpu_bus.predict_sucess !== 1'b0
          || bvi.es_to_bpu_bus.correct_target !== 32'h80000108) begin
         errors++;
         $display("FAIL mnt_bus: got rdy=%b ok=%b tgt=%h expected 1 0 80000108",
                  bvi.es_to_bpu_bus.ready, bvi.es_to_bpu_bus.predict_sucess,
                  bvi.es_to_bpu_bus.correct_target);
      end
      checks++;
      if (dut.state_q !== 2'd1 || bvi.br_cnt !== 4'd2
          || bvi.miss_cnt !== 4'd1) begin
         errors++;
         $display("FAIL mnt_cnt: got st=%0d br=%0d miss=%0d expected 1 2 1",
                  dut.state_q, bvi.br_cnt, bvi.miss_cnt);
      end
      bvi.fs_redirect_ack = 1'b1;
      tick;
      clear_in;
      checks++;
      if (dut.state_q !== 2'd1 || bvi.es_to_bpu_bus.ready !== 1'b0) begin
         errors++;
         $display("FAIL mnt_ack_ignored: got st=%0d rdy=%b expected 1 0",
                  dut.state_q, bvi.es_to_bpu_bus.ready);
      end
      bvi.ds_fire = 1'b1;
      tick;
      clear_in;
      checks++;
      if (dut.state_q !== 2'd2 || bvi.correct_finish !== 1'b0) begin
         errors++;
         $display("FAIL mnt_ds: got st=%0d cf=%b expected 2 0",
                  dut.state_q, bvi.correct_finish);
      end
      bvi.fs_redirect_ack = 1'b1;
      tick;
      clear_in;
      checks++;
      if (dut.state_q !== 2'd0 || bvi.correct_finish !== 1'b1) begin
         errors++;
         $display("FAIL mnt_finish: got st=%0d cf=%b expected 0 1",
                  dut.state_q, bvi.correct_finish);
      end
      tick;
      checks++;
      if (bvi.correct_finish !== 1'b0) begin
         errors++;
         $display("FAIL mnt_pulse: got cf=%b expected 0", bvi.correct_finish);
      end
   endtask

   task automatic test_target_mismatch;
      drive_br(32'h80000100, 3'd1, 1'b1, 32'h80000200,
               1'b1, 1'b1, 32'h80000300);
      tick;
      clear_in;
      checks++;
      if (bvi.es_to_bpu_bus.predict_sucess !== 1'b0
          || bvi.es_to_bpu_bus.correct_target !== 32'h80000200
          || dut.state_q !== 2'd1) begin
         errors++;
         $display("FAIL tm_bus: got ok=%b tgt=%h st=%0d expected 0 80000200 1",
                  bvi.es_to_bpu_bus.predict_sucess,
                  bvi.es_to_bpu_bus.correct_target, dut.state_q);
      end
      checks++;
      if (bvi.br_cnt !== 4'd3 || bvi.miss_cnt !== 4'd2) begin
         errors++;
         $display("FAIL tm_cnt: got br=%0d miss=%0d expected 3 2",
                  bvi.br_cnt, bvi.miss_cnt);
      end
      bvi.ds_fire = 1'b1;
      bvi.fs_redirect_ack = 1'b1;
      tick;
      clear_in;
      checks++;
      if (dut.state_q !== 2'd2 || bvi.correct_finish !== 1'b0) begin
         errors++;
         $display("FAIL tm_ds_ack: got st=%0d cf=%b expected 2 0",
                  dut.state_q, bvi.correct_finish);
      end
      bvi.fs_redirect_ack = 1'b1;
      tick;
      clear_in;
      checks++;
      if (dut.state_q !== 2'd0 || bvi.correct_finish !== 1'b1) begin
         errors++;
         $display("FAIL tm_finish: got st=%0d cf=%b expected 0 1",
                  dut.state_q, bvi.correct_finish);
      end
   endtask

   task automatic test_wrap;
      drive_br(32'hFFFFFFFC, 3'd2, 1'b0, 32'h00000000,
               1'b0, 1'b0, 32'h00000000);
      tick;
      clear_in;
      checks++;
      if (bvi.es_to_bpu_bus.correct_target !== 32'h00000004
          || bvi.es_to_bpu_bus.predict_sucess !== 1'b1
          || bvi.es_to_bpu_bus.br_type !== 3'd2) begin
         errors++;
         $display("FAIL wrap_bus: got tgt=%h ok=%b ty=%0d expected 00000004 1 2",
                  bvi.es_to_bpu_bus.correct_target,
                  bvi.es_to_bpu_bus.predict_sucess, bvi.es_to_bpu_bus.br_type);
      end
      checks++;
      if (dut.state_q !== 2'd0 || bvi.br_cnt !== 4'd4
          || bvi.miss_cnt !== 4'd2 || bvi.correct_finish !== 1'b0) begin
         errors++;
         $display("FAIL wrap_cnt: got st=%0d br=%0d miss=%0d cf=%b",
                  dut.state_q, bvi.br_cnt, bvi.miss_cnt, bvi.correct_finish);
      end
   endtask

   task automatic test_flush;
      drive_br(32'h80000400, 3'd1, 1'b1, 32'h80000500,
               1'b0, 1'b0, 32'h00000000);
      tick;
      clear_in;
      checks++;
      if (dut.state_q !== 2'd1 || bvi.br_cnt !== 4'd5
          || bvi.miss_cnt !== 4'd3) begin
         errors++;
         $display("FAIL fl_setup: got st=%0d br=%0d miss=%0d expected 1 5 3",
                  dut.state_q, bvi.br_cnt, bvi.miss_cnt);
      end
      drive_br(32'h80000500, 3'd1, 1'b1, 32'h80000600,
               1'b1, 1'b1, 32'h80000600);
      tick;
      clear_in;
      checks++;
      if (bvi.es_to_bpu_bus.ready !== 1'b0 || bvi.br_cnt !== 4'd5
          || dut.state_q !== 2'd1) begin
         errors++;
         $display("FAIL fl_wrong_path: got rdy=%b br=%0d st=%0d expected 0 5 1",
                  bvi.es_to_bpu_bus.ready, bvi.br_cnt, dut.state_q);
      end
      bvi.ds_fire = 1'b1;
      tick;
      clear_in;
      bvi.pipeline_flush.ex = 1'b1;
      bvi.fs_redirect_ack = 1'b1;
      tick;
      clear_in;
      checks++;
      if (dut.state_q !== 2'd0 || bvi.correct_finish !== 1'b0) begin
         errors++;
         $display("FAIL fl_redirect: got st=%0d cf=%b expected 0 0",
                  dut.state_q, bvi.correct_finish);
      end
      tick;
      checks++;
      if (bvi.correct_finish !== 1'b0) begin
         errors++;
         $display("FAIL fl_no_pulse: got cf=%b expected 0", bvi.correct_finish);
      end
      drive_br(32'h80000700, 3'd1, 1'b0, 32'h80000800,
               1'b1, 1'b1, 32'h80000800);
      bvi.pipeline_flush.eret = 1'b1;
      tick;
      clear_in;
      checks++;
      if (bvi.es_to_bpu_bus.ready !== 1'b0 || bvi.br_cnt !== 4'd5
          || bvi.miss_cnt !== 4'd3 || dut.state_q !== 2'd0) begin
         errors++;
         $display("FAIL fl_squash: got rdy=%b br=%0d miss=%0d st=%0d",
                  bvi.es_to_bpu_bus.ready, bvi.br_cnt, bvi.miss_cnt,
                  dut.state_q);
      end
   endtask

   task automatic test_saturation;
      @(negedge clk);
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      for (int i = 0; i < 15; i++) do_mispredict;
      checks++;
      if (bvi.br_cnt !== 4'hF || bvi.miss_cnt !== 4'hF) begin
         errors++;
         $display("FAIL sat_fill: got br=%h miss=%h expected f f",
                  bvi.br_cnt, bvi.miss_cnt);
      end
      drive_br(32'h80000100, 3'd1, 1'b0, 32'h80000200,
               1'b1, 1'b1, 32'h80000200);
      tick;
      clear_in;
      checks++;
      if (bvi.br_cnt !== 4'hF || bvi.miss_cnt !== 4'hF
          || bvi.es_to_bpu_bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL sat_hold: got br=%h miss=%h rdy=%b expected f f 1",
                  bvi.br_cnt, bvi.miss_cnt, bvi.es_to_bpu_bus.ready);
      end
   endtask

   task automatic test_async_reset;
      checks++;
      if (dut.state_q !== 2'd1) begin
         errors++;
         $display("FAIL ar_setup: got st=%0d expected 1", dut.state_q);
      end
      #3;
      resetn = 1'b0;
      #1;
      checks++;
      if (bvi.es_to_bpu_bus !== '0 || bvi.correct_finish !== 1'b0) begin
         errors++;
         $display("FAIL ar_bus: got %h cf=%b expected 0 0",
                  bvi.es_to_bpu_bus, bvi.correct_finish);
      end
      checks++;
      if (bvi.br_cnt !== 4'd0 || bvi.miss_cnt !== 4'd0
          || dut.state_q !== 2'd0) begin
         errors++;
         $display("FAIL ar_regs: got br=%0d miss=%0d st=%0d expected 0 0 0",
                  bvi.br_cnt, bvi.miss_cnt, dut.state_q);
      end
      #2;
      resetn = 1'b1;
      bvi.ds_fire = 1'b1;
      tick;
      clear_in;
      bvi.fs_redirect_ack = 1'b1;
      tick;
      clear_in;
      checks++;
      if (bvi.es_to_bpu_bus.ready !== 1'b0 || bvi.correct_finish !== 1'b0
          || dut.state_q !== 2'd0) begin
         errors++;
         $display("FAIL ar_resume: got rdy=%b cf=%b st=%0d expected 0 0 0",
                  bvi.es_to_bpu_bus.ready, bvi.correct_finish, dut.state_q);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset;
      test_correct_taken;
      test_mispredict_nt;
      test_target_mismatch;
      test_wrap;
      test_flush;
      test_saturation;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_verify.md
BRANCH_VERIFY -- requirements
Module: branch_verify

Interface
REQ-001 Parameter: CNT_W, default 32, width of statistics counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 pipeline_flush  input  pipeline_flush_t  fields ex/eret/tlb_op; any set = flush.
REQ-005 es_fire  input  1  EX instruction leaves EX this cycle.
REQ-006 es_pc  input  virt_t  PC of EX instruction.
REQ-007 es_br_type  input  3  resolved branch class; 0 = not a branch.
REQ-008 es_br_taken  input  1  resolved direction.
REQ-009 es_br_target  input  virt_t  resolved taken target.
REQ-010 es_pred  input  predict_result_t  prediction carried with the instruction (valid, br_op, br_taken, target).
REQ-011 es_pred_entry  input  BHT_entry_t  BHT entry read at fetch.
REQ-012 ds_fire  input  1  delay-slot instruction leaves EX this cycle.
REQ-013 fs_redirect_ack  input  1  fetch has issued the corrected PC.
REQ-014 es_to_bpu_bus  output  verify_result_t  fields pc, br_type, ready, predict_sucess, is_taken, correct_target, predict_entry.
REQ-015 correct_finish  output  1  one-cycle pulse ending a correction.
REQ-016 br_cnt, miss_cnt  output  CNT_W each  verified-branch and misprediction counters.

Function
REQ-017 Branch fire = es_fire && es_br_type != 0 && state == IDLE && no flush this cycle.
REQ-018 actual target = es_br_taken ? es_br_target : es_pc + 8, 32-bit, wrap modulo 2^32.
REQ-019 predicted taken = es_pred.valid && es_pred.br_op && es_pred.br_taken; predicted target = es_pred.target when predicted taken, else es_pc + 8.
REQ-020 predict_sucess = (predicted taken == es_br_taken) && (!es_br_taken || predicted target == es_br_target).
REQ-021 es_to_bpu_bus registered: latency 1; ready high exactly the cycle after a branch fire, low otherwise.
REQ-022 During the ready cycle, pc/br_type/is_taken/correct_target/predict_entry/predict_sucess hold the fired branch's values; other cycles retain last values (ready=0 qualifies).
REQ-023 FSM states IDLE, WAIT_DS, REDIRECT.
REQ-024 IDLE -> WAIT_DS on branch fire with predict_sucess=0; otherwise stay IDLE.
REQ-025 WAIT_DS -> REDIRECT on ds_fire; fs_redirect_ack ignored in WAIT_DS.
REQ-026 REDIRECT -> IDLE on fs_redirect_ack; correct_finish registered, high the cycle after the ack, for one cycle.
REQ-027 Branch fires in WAIT_DS/REDIRECT (wrong path) produce no ready pulse, no counter update.
REQ-028 Flush (any pipeline_flush field) wins over every event: state -> IDLE, pending ready pulse and correct_finish cancelled next cycle; counters unchanged by the squashed branch.
REQ-029 br_cnt +1 per ready pulse; miss_cnt +1 per ready pulse with predict_sucess=0; both saturate at all-ones.
REQ-030 ds_fire and fs_redirect_ack in the same WAIT_DS cycle: move to REDIRECT only; ack must recur.

Reset
REQ-031 resetn low: state IDLE, es_to_bpu_bus all zero, correct_finish 0, br_cnt 0, miss_cnt 0, immediately (asynchronous).
REQ-032 Reset deasserted mid-correction: resumes in IDLE; no stale ready or correct_finish pulse.

Verification
REQ-033 Correct taken: pc=0x80000100, br_type=BRA, taken, target 0x80000200, pred taken target 0x80000200 -> next cycle ready=1, predict_sucess=1, correct_target=0x80000200, state IDLE, br_cnt=1, miss_cnt=0.
REQ-034 Mispredict not-taken: pc=0x80000100, pred taken 0x80000200, actual not taken -> ready=1, predict_sucess=0, correct_target=0x80000108; ds_fire -> REDIRECT; ack -> correct_finish=1 one cycle later; miss_cnt=1.
REQ-035 Target mismatch: both taken, pred 0x80000300, actual 0x80000200 -> predict_sucess=0, correct_target=0x80000200.
REQ-036 Flush in REDIRECT with ack same cycle -> IDLE, correct_finish stays 0; second branch fire in WAIT_DS before flush -> no ready pulse.
REQ-037 Saturation: preload miss_cnt/br_cnt to all-ones via 2^CNT_W-1 mispredicts (CNT_W=4) -> both stay 0xF on next mispredict.
REQ-038 Async reset asserted between clock edges in WAIT_DS -> outputs zero before next edge.
